conv_mc_top: RTL and testbench
==============================

CONV_MC_TOP -- requirements
Module: conv_mc_top

Interface
REQ-001 SHALL have parameter DataWidth, default 16: signed pixel and coefficient width.
REQ-002 SHALL have parameter Ch, default 2: input channels per pixel beat.
REQ-003 SHALL have parameter ImgW, default 4: pixels per row (minimum 3).
REQ-004 SHALL have parameter ImgH, default 4: rows per frame (minimum 3).
REQ-005 SHALL have parameter Shift, default 0: arithmetic right shift applied to the channel sum.
REQ-006 SHALL have port i_clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port i_pixel_data, input, DataWidth*Ch: one pixel, all channels; channel c at bits [c*DataWidth +: DataWidth].
REQ-009 SHALL have port i_pixel_valid, input, 1: pixel beat offered.
REQ-010 SHALL have port o_pixel_ready, output, 1: pixel beat accepted when valid and ready are both high.
REQ-011 SHALL have port i_kernel_wr, input, 1: coefficient write strobe.
REQ-012 SHALL have port i_kernel_addr, input, $clog2(9*Ch): address = c*9 + k; k is the row-major tap index, 0 = oldest row, oldest column.
REQ-013 SHALL have port i_kernel_data, input, DataWidth: signed coefficient.
REQ-014 SHALL have port i_frame_start, input, 1: synchronous restart of the frame counters.
REQ-015 SHALL have port o_conv_data, output, DataWidth: signed result.
REQ-016 SHALL have port o_conv_valid, output, 1: result valid.
REQ-017 SHALL have port i_conv_ready, input, 1: downstream accepts the result.

Function
REQ-018 SHALL define en = !o_conv_valid || i_conv_ready; o_pixel_ready = en; all pipeline stages SHALL hold when en is low.
REQ-019 SHALL hold, per channel, two row line buffers of ImgW entries and a 3x3 window; the buffers and window SHALL update only on an accepted beat.
REQ-020 SHALL track col (0..ImgW-1) and row (0..ImgH-1); col SHALL wrap to 0 and increment row; after pixel (ImgH-1, ImgW-1), both counters SHALL return to 0 (back-to-back frames).
REQ-021 SHALL implement FSM states FILL (row<2) and RUN (row>=2); FILL->RUN on the accepted beat at col=ImgW-1, row=1; RUN->FILL on the last pixel of the frame.
REQ-022 SHALL mark the window as valid on an accepted beat with row>=2 and col>=2 (no padding), giving (ImgW-2)*(ImgH-2) outputs per frame.
REQ-023 SHALL use a 3-stage pipeline: S1 registers the 9*Ch full-width products; S2 registers the sum of all products; S3 registers the shifted and converted result into o_conv_data.
REQ-024 Latency SHALL be: o_conv_valid high after the 3rd rising edge, counting the accepting edge as the 1st, when unstalled.
REQ-025 The accumulator SHALL be 2*DataWidth+$clog2(9*Ch)+1 bits signed; there SHALL be no intermediate truncation.
REQ-026 While o_conv_valid=1 and i_conv_ready=0, o_conv_data SHALL be held stable.
REQ-027 A kernel write to an address >= 9*Ch SHALL be ignored.
REQ-028 A valid kernel write SHALL take effect for products registered on the following edge.
REQ-029 Kernel writes SHALL be accepted regardless of en.
REQ-030 i_frame_start SHALL zero row, col and the FSM state (to FILL); it SHALL take priority over a simultaneous accepted beat, and that beat SHALL be dropped.
REQ-031 i_frame_start SHALL NOT cancel results already in flight in S1-S3.

Reset
REQ-032 While i_rst_n=0, the block SHALL immediately clear o_conv_valid=0, o_conv_data=0, all stage valids, row, col, FSM=FILL and all coefficients.
REQ-033 o_pixel_ready SHALL be 1 in reset.
REQ-034 Line buffer contents SHALL be don't-care after reset.
REQ-035 Reset asserted mid-frame SHALL discard all in-flight results; the next accepted beat SHALL be pixel (0,0).

Configuration
REQ-036 With CONV_SAT_EN defined, S3 SHALL saturate the shifted sum to [-2^(DataWidth-1), 2^(DataWidth-1)-1].
REQ-037 Without CONV_SAT_EN, S3 SHALL take the low DataWidth bits of the shifted sum (wrap).

Verification (DataWidth=16, Ch=2, ImgW=ImgH=4, Shift=0)
REQ-038 SHALL cover: ch0 kernel all 1, ch1 kernel 0, all pixels ch0=1 streamed continuously -> exactly 4 outputs of 9; first o_conv_valid on the 3rd edge counting the edge accepting pixel (2,2) as the 1st.
REQ-039 SHALL cover: tap 4 = 1 on both channels, ch0 = row*4+col, ch1 = 100 -> outputs 105, 106, 109, 110 in order.
REQ-040 SHALL cover: ch0 taps and pixels all 0x7FFF, ch1 = 0 -> output 0x7FFF with CONV_SAT_EN, 0x0009 without.
REQ-041 SHALL cover: i_conv_ready=0 for 5 cycles while o_conv_valid=1 -> o_pixel_ready=0, o_conv_data unchanged, no result lost or duplicated.
REQ-042 SHALL cover: i_rst_n pulsed low after 6 accepted beats -> outputs 0 immediately, coefficients 0; after reload, a full frame yields 4 outputs.
REQ-043 SHALL cover: two back-to-back frames plus i_frame_start asserted with a beat at pixel (1,3) -> 8 outputs for the two clean frames; the interrupted frame restarts at (0,0) and the dropped beat is not counted.

Source files
------------

// File: rtl/conv_mc_top.sv
// Multi-channel 3x3 streaming convolution with a 3-stage MAC pipeline and backpressure.
// Define CONV_SAT_EN to saturate the output; by default the result wraps to DataWidth bits.
module conv_mc_top #(
  parameter int DataWidth = 16,
  parameter int Ch        = 2,
  parameter int ImgW      = 4,
  parameter int ImgH      = 4,
  parameter int Shift     = 0
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [DataWidth*Ch-1:0]     i_pixel_data,
  input  logic                        i_pixel_valid,
  output logic                        o_pixel_ready,
  input  logic                        i_kernel_wr,
  input  logic [$clog2(9*Ch)-1:0]     i_kernel_addr,
  input  logic [DataWidth-1:0]        i_kernel_data,
  input  logic                        i_frame_start,
  output logic [DataWidth-1:0]        o_conv_data,
  output logic                        o_conv_valid,
  input  logic                        i_conv_ready
);

  localparam int unsigned NTap = 9 * Ch;
  localparam int unsigned PW   = 2 * DataWidth;
  localparam int unsigned AccW = PW + $clog2(NTap) + 1;
  localparam int unsigned ColW = $clog2(ImgW);
  localparam int unsigned RowW = $clog2(ImgH);

  localparam logic [0:0] StFill = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic             en;
  logic             beat;
  logic             win_ok;
  logic             last_col;
  logic             last_row;
  logic [ColW-1:0]  col;
  logic [RowW-1:0]  row;
  logic [0:0]       state;

  logic signed [DataWidth-1:0] coef   [NTap];
  logic signed [DataWidth-1:0] lb0    [Ch][ImgW];
  logic signed [DataWidth-1:0] lb1    [Ch][ImgW];
  logic signed [DataWidth-1:0] win    [Ch][3][3];
  logic signed [DataWidth-1:0] win_nx [Ch][3][3];
  logic signed [PW-1:0]        prod_nx [NTap];
  logic signed [PW-1:0]        prod    [NTap];
  logic signed [AccW-1:0]      acc;
  logic signed [AccW-1:0]      s2_sum;
  logic [DataWidth-1:0]        res;
  logic                        s1_vld;
  logic                        s2_vld;

  assign en            = !o_conv_valid || i_conv_ready;
  assign o_pixel_ready = en;
  // A beat coinciding with a frame restart is consumed but discarded.
  assign beat     = i_pixel_valid && en && !i_frame_start;
  assign last_col = (col == ColW'(ImgW - 1));
  assign last_row = (row == RowW'(ImgH - 1));
  assign win_ok   = beat && (state == StRun) && (col >= ColW'(2));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col   <= '0;
      row   <= '0;
      state <= StFill;
    end else if (i_frame_start) begin
      col   <= '0;
      row   <= '0;
      state <= StFill;
    end else if (beat) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      case (state)
        StFill:  if (last_col && (row == RowW'(1))) state <= StRun;
        default: if (last_col && last_row) state <= StFill;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NTap; i++) coef[i] <= '0;
    end else if (i_kernel_wr && (32'(i_kernel_addr) < NTap)) begin
      coef[i_kernel_addr] <= i_kernel_data;
    end
  end

  // Next window: shift columns left, new column = {row-2, row-1, current pixel}.
  for (genvar c = 0; c < Ch; c++) begin : g_win
    for (genvar r = 0; r < 3; r++) begin : g_row
      assign win_nx[c][r][0] = win[c][r][1];
      assign win_nx[c][r][1] = win[c][r][2];
      for (genvar j = 0; j < 3; j++) begin : g_tap
        assign prod_nx[c*9 + r*3 + j] = PW'(win_nx[c][r][j]) * PW'(coef[c*9 + r*3 + j]);
      end
    end
    assign win_nx[c][0][2] = lb0[c][col];
    assign win_nx[c][1][2] = lb1[c][col];
    assign win_nx[c][2][2] = i_pixel_data[c*DataWidth +: DataWidth];
  end

  always_ff @(posedge i_clk) begin
    if (beat) begin
      for (int unsigned c = 0; c < Ch; c++) begin
        lb0[c][col] <= lb1[c][col];
        lb1[c][col] <= i_pixel_data[c*DataWidth +: DataWidth];
      end
      win <= win_nx;
    end
  end

  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < NTap; i++) acc = acc + AccW'(prod[i]);
  end

`ifdef CONV_SAT_EN
  logic signed [AccW-1:0] sh;
  assign sh = s2_sum >>> Shift;
  always_comb begin
    res = sh[DataWidth-1:0];
    if (!((&sh[AccW-1:DataWidth-1]) || !(|sh[AccW-1:DataWidth-1])))
      res = sh[AccW-1] ? {1'b1, {(DataWidth-1){1'b0}}} : {1'b0, {(DataWidth-1){1'b1}}};
  end
`else
  always_comb begin
    res = DataWidth'(s2_sum >>> Shift);
  end
`endif

  always_ff @(posedge i_clk) begin
    if (en) begin
      prod   <= prod_nx;
      s2_sum <= acc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld       <= 1'b0;
      s2_vld       <= 1'b0;
      o_conv_valid <= 1'b0;
      o_conv_data  <= '0;
    end else if (en) begin
      s1_vld       <= win_ok;
      s2_vld       <= s1_vld;
      o_conv_valid <= s2_vld;
      if (s2_vld) o_conv_data <= res;
    end
  end

endmodule

// File: tb/tb_conv_mc_top.sv
// Directed bench for conv_mc_top at DataWidth=16, Ch=2, ImgW=ImgH=4, Shift=0.
module tb_conv_mc_top;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic [31:0] i_pixel_data = '0;
  logic        i_pixel_valid = 1'b0;
  logic        o_pixel_ready;
  logic        i_kernel_wr = 1'b0;
  logic [4:0]  i_kernel_addr = '0;
  logic [15:0] i_kernel_data = '0;
  logic        i_frame_start = 1'b0;
  logic [15:0] o_conv_data;
  logic        o_conv_valid;
  logic        i_conv_ready = 1'b1;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int          base = 0;
  logic [15:0] held;
  logic [15:0]  outq [$];
  int unsigned  cycq [$];

  conv_mc_top #(.DataWidth(16), .Ch(2), .ImgW(4), .ImgH(4), .Shift(0)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_pixel_data  (i_pixel_data),
    .i_pixel_valid (i_pixel_valid),
    .o_pixel_ready (o_pixel_ready),
    .i_kernel_wr   (i_kernel_wr),
    .i_kernel_addr (i_kernel_addr),
    .i_kernel_data (i_kernel_data),
    .i_frame_start (i_frame_start),
    .o_conv_data   (o_conv_data),
    .o_conv_valid  (o_conv_valid),
    .i_conv_ready  (i_conv_ready)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Handshake completes on the next rising edge when valid && ready at the falling edge.
  always @(negedge i_clk) begin
    if (i_rst_n && o_conv_valid && i_conv_ready) begin
      outq.push_back(o_conv_data);
      cycq.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_val(input int mode, input int idx);
    logic [15:0] v;
    case (mode)
      0: v = 16'd9;
      1: case (idx % 4)
           0:       v = 16'd105;
           1:       v = 16'd106;
           2:       v = 16'd109;
           default: v = 16'd110;
         endcase
`ifdef CONV_SAT_EN
      2: v = 16'h7fff;
`else
      2: v = 16'h0009;
`endif
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] px_val(input int mode, input int idx);
    logic [31:0] v;
    case (mode)
      0:       v = {16'd0, 16'd1};
      1:       v = {16'd100, 16'(idx)};
      default: v = {16'd0, 16'h7fff};
    endcase
    return v;
  endfunction

  task automatic kwr(input int addr, input logic [15:0] data);
    i_kernel_wr   = 1'b1;
    i_kernel_addr = 5'(addr);
    i_kernel_data = data;
    @(posedge i_clk); #1;
    i_kernel_wr = 1'b0;
  endtask

  task automatic load_kernel(input int mode);
    logic [15:0] d;
    for (int a = 0; a < 18; a++) begin
      case (mode)
        0:       d = (a < 9) ? 16'd1 : 16'd0;
        1:       d = (a == 4 || a == 13) ? 16'd1 : 16'd0;
        default: d = (a < 9) ? 16'h7fff : 16'd0;
      endcase
      kwr(a, d);
    end
    kwr(18, 16'h1234);
    kwr(31, 16'h1234);
  endtask

  task automatic send_px(input logic [31:0] px, input logic fs);
    bit ok = 1'b0;
    i_pixel_data  = px;
    i_pixel_valid = 1'b1;
    i_frame_start = fs;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge i_clk);
      ok = o_pixel_ready;
      @(posedge i_clk); #1;
    end
    if (!ok) check("px_accept_timeout", 32'd0, 32'd1);
    i_pixel_valid = 1'b0;
    i_frame_start = 1'b0;
  endtask

  task automatic send_frame(input int mode, input int stop_at);
    bit done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      if (i == stop_at) begin
        send_px(px_val(mode, i), 1'b1);
        done = 1'b1;
      end else begin
        send_px(px_val(mode, i), 1'b0);
        if (i == 10) acc_cyc = cyc;
      end
    end
  endtask

  task automatic drain();
    repeat (8) @(posedge i_clk);
    #1;
  endtask

  task automatic check_q(input int mode, input int nfr, input int b);
    int n;
    n = outq.size() - b;
    check($sformatf("count_m%0d", mode), 32'(n), 32'(4 * nfr));
    for (int i = 0; i < n && i < 4 * nfr; i++)
      check($sformatf("value_m%0d_%0d", mode, i), 32'(outq[b + i]), 32'(exp_val(mode, i)));
  endtask

  initial begin
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(o_conv_valid), 32'd0);
    check("rst_data", 32'(o_conv_data), 32'd0);
    check("rst_pready", 32'(o_pixel_ready), 32'd1);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Box filter on ch0 of a constant frame, plus first-result latency.
    load_kernel(0);
    base = outq.size();
    send_frame(0, -1);
    drain();
    check_q(0, 1, base);
    if (cycq.size() > base) check("latency", 32'(cycq[base] - acc_cyc), 32'd2);
    else check("latency", 32'hffffffff, 32'd2);

    // Centre tap on both channels picks out the middle pixel + 100.
    load_kernel(1);
    base = outq.size();
    send_frame(1, -1);
    drain();
    check_q(1, 1, base);

    // Overflowing sum: wraps by default, clamps with saturation enabled.
    load_kernel(2);
    base = outq.size();
    send_frame(2, -1);
    drain();
    check_q(2, 1, base);

    // Downstream stall for five cycles on the first result.
    load_kernel(1);
    base = outq.size();
    fork
      send_frame(1, -1);
      begin : stall
        bit got;
        got = 1'b0;
        for (int n = 0; n < 80 && !got; n++) begin
          @(posedge i_clk); #2;
          got = o_conv_valid;
        end
        if (!got) check("stall_wait", 32'd0, 32'd1);
        else begin
          held = o_conv_data;
          i_conv_ready = 1'b0;
          check("stall_first", 32'(held), 32'd105);
          repeat (5) begin
            @(negedge i_clk);
            check("stall_pready", 32'(o_pixel_ready), 32'd0);
            check("stall_hold", 32'(o_conv_data), 32'(held));
            check("stall_valid", 32'(o_conv_valid), 32'd1);
          end
          @(posedge i_clk); #2;
          i_conv_ready = 1'b1;
        end
      end
    join
    drain();
    check_q(1, 1, base);

    // Mid-frame reset clears outputs and coefficients.
    for (int i = 0; i < 6; i++) send_px(px_val(1, i), 1'b0);
    check("pre_rst_data", 32'(o_conv_data), 32'd110);
    i_rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(o_conv_valid), 32'd0);
    check("mrst_data", 32'(o_conv_data), 32'd0);
    check("mrst_pready", 32'(o_pixel_ready), 32'd1);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    base = outq.size();
    send_frame(1, -1);
    drain();
    check_q(3, 1, base);
    load_kernel(1);
    base = outq.size();
    send_frame(1, -1);
    drain();
    check_q(1, 1, base);

    // Two clean frames, an interrupted one (restart at pixel (1,3)), then a clean restart.
    base = outq.size();
    send_frame(1, -1);
    send_frame(1, -1);
    send_frame(1, 7);
    drain();
    check("two_frames", 32'(outq.size() - base), 32'd8);
    send_frame(1, -1);
    drain();
    check_q(1, 3, base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
